// File: rtl/inst_fetch_queue_pkg.sv
// Shared CPU constants and the fetch-stage state encoding.
package cpu_pkg;
   localparam int                INST_W   = 32;
   localparam int                PC_W     = 64;
   localparam logic [PC_W-1:0]   RESET_PC = '0;
   localparam logic [INST_W-1:0] NOP_INST = 32'd0;

   typedef enum logic [1:0] {
      FS_BOOT   = 2'd0,
      FS_RUN    = 2'd1,
      FS_HALTED = 2'd2
   } fetch_state_e;
endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect/halt control and decode handshake.
interface inst_fetch_queue_if #(
   parameter int PC_W   = cpu_pkg::PC_W,
   parameter int INST_W = cpu_pkg::INST_W
);
   logic              imem_req_valid;
   logic [PC_W-1:0]   imem_req_addr;
   logic              imem_req_ready;
   logic              imem_rsp_valid;
   logic [INST_W-1:0] imem_rsp_data;
   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_pc;
   logic              hlt;
   logic              if_valid;
   logic [INST_W-1:0] if_inst;
   logic [PC_W-1:0]   if_pc;
   logic [PC_W-1:0]   if_pc_inc;
   logic              id_ready;

   // master is the fetch unit, slave is the memory/decode environment
   modport master (
      output imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc, if_pc_inc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, hlt, id_ready
   );
   modport slave (
      input  imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc, if_pc_inc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, hlt, id_ready
   );
endinterface

// File: rtl/inst_fetch_queue_inst_queue.sv
// In-order {pc, inst} FIFO with flush and a combinational head read.
module inst_queue #(
   parameter int DEPTH  = 4,
   parameter int PC_W   = cpu_pkg::PC_W,
   parameter int INST_W = cpu_pkg::INST_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [PC_W-1:0]          push_pc,
   input  logic [INST_W-1:0]        push_inst,
   input  logic                     pop,
   input  logic                     flush,
   output logic [PC_W-1:0]          head_pc,
   output logic [INST_W-1:0]        head_inst,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int          AW     = $clog2(DEPTH);
   localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

   logic [PC_W-1:0]   pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign do_pop  = pop && (count != '0) && !flush;
   assign do_push = push && !flush && ((count != FULL_C) || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   // Storage carries no reset; the head is only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (do_push) begin
         pc_mem[wr_ptr]   <= push_pc;
         inst_mem[wr_ptr] <= push_inst;
      end
   end

   assign head_pc   = pc_mem[rd_ptr];
   assign head_inst = inst_mem[rd_ptr];
endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: issues sequential fetches, queues returned instructions for decode,
// flushes on redirect and stops for good on halt.
module inst_fetch_queue import cpu_pkg::*; #(
   parameter int              DEPTH    = 4,
   parameter int              PC_W     = cpu_pkg::PC_W,
   parameter int              INST_W   = cpu_pkg::INST_W,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(cpu_pkg::RESET_PC)
) (
   input logic                clk,
   input logic                rst_n,
   inst_fetch_queue_if.master bus
);
   localparam int          CW      = $clog2(DEPTH) + 1;
   // Stale responses can pile up across back-to-back redirects, so give them headroom.
   localparam int          SW      = CW + 4;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_state_e      state;
   logic [PC_W-1:0]   fetch_pc;
   logic [PC_W-1:0]   rsp_pc;
   logic [CW-1:0]     live;
   logic [CW-1:0]     count;
   logic [SW-1:0]     stale;
   logic [SW-1:0]     stale_flush;
   logic [PC_W-1:0]   head_pc;
   logic [INST_W-1:0] head_inst;
   logic              run;
   logic              redir;
   logic              accept;
   logic              rsp_stale;
   logic              rsp_live;
   logic              push;
   logic              pop;

   assign run       = (state == FS_RUN);
   assign redir     = run && bus.redirect_valid && !bus.hlt;
   assign accept    = bus.imem_req_valid && bus.imem_req_ready;
   assign rsp_stale = bus.imem_rsp_valid && (stale != '0);
   assign rsp_live  = bus.imem_rsp_valid && (stale == '0) && (live != '0);
   assign push      = rsp_live && run && !redir;
   assign pop       = bus.if_valid && bus.id_ready && !redir;

   // Everything still in flight at a redirect becomes stale, minus the response consumed now.
   assign stale_flush = stale + SW'(live) - SW'(rsp_stale || rsp_live);

   assign bus.imem_req_valid = run && !bus.redirect_valid && ((live + count) < DEPTH_C);
   assign bus.imem_req_addr  = fetch_pc;
   assign bus.if_valid       = run && (count != '0);
   assign bus.if_inst        = bus.if_valid ? head_inst : INST_W'(NOP_INST);
   assign bus.if_pc          = bus.if_valid ? head_pc : '0;
   assign bus.if_pc_inc      = bus.if_valid ? head_pc + 1'b1 : '0;

   inst_queue #(
      .DEPTH  (DEPTH),
      .PC_W   (PC_W),
      .INST_W (INST_W)
   ) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_pc   (rsp_pc),
      .push_inst (bus.imem_rsp_data),
      .pop       (pop),
      .flush     (redir),
      .head_pc   (head_pc),
      .head_inst (head_inst),
      .count     (count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FS_BOOT;
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         live     <= '0;
         stale    <= '0;
      end else begin
         case (state)
            FS_BOOT: state <= FS_RUN;
            FS_RUN:  if (bus.hlt) state <= FS_HALTED;
            default: state <= state;
         endcase

         if (redir) begin
            live     <= '0;
            stale    <= stale_flush;
            fetch_pc <= bus.redirect_pc;
            rsp_pc   <= bus.redirect_pc;
         end else begin
            if (accept)    fetch_pc <= fetch_pc + 1'b1;
            if (push)      rsp_pc   <= rsp_pc + 1'b1;
            if (rsp_stale) stale    <= stale - 1'b1;
            if (accept && !rsp_live)      live <= live + 1'b1;
            else if (!accept && rsp_live) live <= live - 1'b1;
         end
      end
   end

   a_rsp_orphan: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.imem_rsp_valid && (live == '0) && (stale == '0)));
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with an in-order instruction memory of configurable latency.
module tb_inst_fetch_queue;
   import cpu_pkg::*;

   typedef struct {
      logic [PC_W-1:0] addr;
      int              due;
   } pend_t;

   typedef struct {
      logic            idr;
      logic            rv;
      logic [PC_W-1:0] ra;
      logic            iv;
      logic [PC_W-1:0] pc;
   } vec_t;

   logic  clk   = 1'b0;
   logic  rst_n = 1'b1;
   int    errors = 0;
   int    checks = 0;
   int    lat    = 1;
   int    mcyc   = 0;
   pend_t pend[$];
   pend_t np;
   vec_t  tv[23];

   always #5 clk = ~clk;

   inst_fetch_queue_if bus ();

   inst_fetch_queue #(.DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [INST_W-1:0] mem_word(input logic [PC_W-1:0] a);
      return {4'hE, a[27:0]};
   endfunction

   // Memory: drives responses at the falling edge, records the request that the next rising edge accepts.
   initial begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         mcyc++;
         if (pend.size() > 0 && pend[0].due <= mcyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend[0].addr);
            pend.delete(0);
         end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
         end
         #1;
         if (!rst_n) begin
            pend.delete();
         end else if (bus.imem_req_valid && bus.imem_req_ready) begin
            np.addr = bus.imem_req_addr;
            np.due  = mcyc + lat;
            pend.push_back(np);
         end
      end
   end

   task automatic chk(input string nm, input logic [PC_W-1:0] act, input logic [PC_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_out(input string nm, input logic rv, input logic [PC_W-1:0] ra,
                            input logic iv, input logic [PC_W-1:0] pc);
      chk($sformatf("%s.req_valid", nm), PC_W'(bus.imem_req_valid), PC_W'(rv));
      chk($sformatf("%s.req_addr", nm), bus.imem_req_addr, ra);
      chk($sformatf("%s.if_valid", nm), PC_W'(bus.if_valid), PC_W'(iv));
      chk($sformatf("%s.if_pc", nm), bus.if_pc, iv ? pc : '0);
      chk($sformatf("%s.if_inst", nm), PC_W'(bus.if_inst), iv ? PC_W'(mem_word(pc)) : '0);
      chk($sformatf("%s.if_pc_inc", nm), bus.if_pc_inc, iv ? pc + PC_W'(1) : '0);
   endtask

   task automatic drive(input logic idr, input logic rv, input logic [PC_W-1:0] rpc, input logic h);
      @(negedge clk);
      bus.id_ready       = idr;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.hlt            = h;
      #2;
   endtask

   // Asserts reset between edges, optionally checks it took effect at once, releases at a falling edge.
   task automatic do_reset(input bit check_now);
      @(negedge clk);
      #2;
      rst_n              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.hlt            = 1'b0;
      bus.id_ready       = 1'b1;
      #1;
      if (check_now) check_out("async_rst", 1'b0, RESET_PC, 1'b0, '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
   endtask

   task automatic set_vec(input int i, input bit idr, input bit rv, input int ra, input bit iv, input int pc);
      tv[i].idr = idr;
      tv[i].rv  = rv;
      tv[i].ra  = PC_W'(ra);
      tv[i].iv  = iv;
      tv[i].pc  = PC_W'(pc);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   initial begin
      // Cycle 0 is the reset-release cycle; 1-cycle memory, decode stalls for cycles 6..15.
      set_vec(0, 1, 0, 0, 0, 0);
      set_vec(1, 1, 1, 0, 0, 0);
      set_vec(2, 1, 1, 1, 0, 0);
      set_vec(3, 1, 1, 2, 1, 0);
      set_vec(4, 1, 1, 3, 1, 1);
      set_vec(5, 1, 1, 4, 1, 2);
      set_vec(6, 0, 1, 5, 1, 3);
      set_vec(7, 0, 1, 6, 1, 3);
      for (int i = 8; i <= 15; i++) set_vec(i, 0, 0, 7, 1, 3);
      set_vec(16, 1, 0, 7, 1, 3);
      set_vec(17, 1, 1, 7, 1, 4);
      for (int i = 18; i <= 22; i++) set_vec(i, 1, 1, i - 10, 1, i - 13);

      bus.imem_req_ready = 1'b1;
      bus.id_ready       = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.hlt            = 1'b0;
      #1 rst_n = 1'b0;
      #3;
      check_out("reset", 1'b0, RESET_PC, 1'b0, '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #2;

      for (int i = 0; i < 23; i++) begin
         if (i != 0) drive(tv[i].idr, 1'b0, '0, 1'b0);
         check_out($sformatf("tbl%0d", i), tv[i].rv, tv[i].ra, tv[i].iv, tv[i].pc);
      end

      // Reset mid-stream, then fetching restarts at RESET_PC.
      do_reset(1'b1);
      check_out("rst_c0", 1'b0, RESET_PC, 1'b0, '0);
      drive(1'b1, 1'b0, '0, 1'b0);
      check_out("rst_c1", 1'b1, RESET_PC, 1'b0, '0);
      drive(1'b1, 1'b0, '0, 1'b0);
      drive(1'b1, 1'b0, '0, 1'b0);
      check_out("rst_c3", 1'b1, RESET_PC + 2, 1'b1, RESET_PC);

      // Redirect coinciding with a response and a pop.
      do_reset(1'b0);
      drive(1'b1, 1'b0, '0, 1'b0);
      drive(1'b1, 1'b0, '0, 1'b0);
      drive(1'b1, 1'b1, 64'h40, 1'b0);
      check_out("rdA_c3", 1'b0, 64'd2, 1'b1, 64'd0);
      drive(1'b1, 1'b0, '0, 1'b0);
      check_out("rdA_c4", 1'b1, 64'h40, 1'b0, '0);
      drive(1'b1, 1'b0, '0, 1'b0);
      check_out("rdA_c5", 1'b1, 64'h41, 1'b0, '0);
      drive(1'b1, 1'b0, '0, 1'b0);
      check_out("rdA_c6", 1'b1, 64'h42, 1'b1, 64'h40);
      drive(1'b1, 1'b0, '0, 1'b0);
      check_out("rdA_c7", 1'b1, 64'h43, 1'b1, 64'h41);

      // 3-cycle memory, two requests in flight when the redirect hits.
      lat = 3;
      do_reset(1'b0);
      drive(1'b1, 1'b0, '0, 1'b0);
      check_out("rdB_c1", 1'b1, 64'd0, 1'b0, '0);
      drive(1'b1, 1'b0, '0, 1'b0);
      check_out("rdB_c2", 1'b1, 64'd1, 1'b0, '0);
      drive(1'b1, 1'b1, 64'h40, 1'b0);
      check_out("rdB_c3", 1'b0, 64'd2, 1'b0, '0);
      for (int c = 4; c <= 7; c++) begin
         drive(1'b1, 1'b0, '0, 1'b0);
         check_out($sformatf("rdB_c%0d", c), 1'b1, 64'h40 + PC_W'(c - 4), 1'b0, '0);
      end
      drive(1'b1, 1'b0, '0, 1'b0);
      check_out("rdB_c8", 1'b0, 64'h44, 1'b1, 64'h40);
      drive(1'b1, 1'b0, '0, 1'b0);
      check_out("rdB_c9", 1'b1, 64'h44, 1'b1, 64'h41);

      // Halt with two entries queued and one request in flight; a later redirect is ignored.
      lat = 1;
      do_reset(1'b0);
      drive(1'b0, 1'b0, '0, 1'b0);
      drive(1'b0, 1'b0, '0, 1'b0);
      drive(1'b0, 1'b0, '0, 1'b1);
      check_out("hlt_c3", 1'b1, 64'd2, 1'b1, 64'd0);
      drive(1'b0, 1'b0, '0, 1'b0);
      check_out("hlt_c4", 1'b0, 64'd3, 1'b0, '0);
      drive(1'b1, 1'b1, 64'h80, 1'b0);
      check_out("hlt_c5", 1'b0, 64'd3, 1'b0, '0);
      for (int c = 6; c <= 7; c++) begin
         drive(1'b1, 1'b0, '0, 1'b0);
         check_out($sformatf("hlt_c%0d", c), 1'b0, 64'd3, 1'b0, '0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch stage sitting directly upstream of the decode/execute stage. Issues word-addressed fetch requests (PC increments by 1) to the instruction memory, buffers returned instructions with their PCs in a small in-order queue, and presents one instruction per cycle to decode with a valid/ready handshake. It handles branch/jump redirects by flushing the queue and discarding in-flight stale responses, and stops fetching permanently on `hlt`.

## Interface
- `DEPTH`, 4: queue entries and maximum live in-flight requests; power of 2, ≥2.
- `PC_W`, 64: PC width.
- `INST_W`, 32: instruction width.
- `RESET_PC`, 0: first fetch address after reset.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_addr` out PC_W: word address of the request.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_rsp_valid` in 1: response valid; responses arrive in request order, ≥1 cycle after acceptance.
- `imem_rsp_data` in INST_W: fetched instruction.
- `redirect_valid` in 1: taken branch/jump; flush and refetch.
- `redirect_pc` in PC_W: new fetch PC.
- `hlt` in 1: halt decoded by the control unit.
- `if_valid` out 1: head entry valid.
- `if_inst` out INST_W: head instruction.
- `if_pc` out PC_W: head PC.
- `if_pc_inc` out PC_W: head PC + 1 (link value).
- `id_ready` in 1: decode consumes the head this cycle.

## Operation
- FSM states: BOOT → RUN (unconditional, one cycle after reset release); RUN → HALTED when `hlt`=1; HALTED is left only by reset.
- Counters: `count` (queue occupancy, 0..DEPTH), `live` (in-flight requests whose responses are kept), `stale` (in-flight requests whose responses are dropped).
- Issue: in RUN, `imem_req_valid` = !redirect_valid && (live + count < DEPTH). Acceptance occurs when valid && ready: live += 1, fetch_pc += 1 (mod 2^PC_W).
- Response: when `stale`>0 it is decremented and the data is dropped; otherwise live -= 1 and {data, pc} are pushed. The push PC comes from a response-PC register that advances by 1 per kept response.
- Pop: on if_valid && id_ready the head is removed; push and pop in the same cycle leave `count` unchanged.
- Redirect (RUN only): queue is flushed (count ← 0), stale ← stale + live − (imem_rsp_valid ? 1 : 0), live ← 0, and fetch_pc and response-PC are both set to `redirect_pc`. A same-cycle pop and a same-cycle response are dropped. No request is issued in the redirect cycle.
- Halt: from the next cycle, `imem_req_valid`=0 and `if_valid`=0, and the queue is frozen. Outstanding responses are still absorbed (dropped) and `redirect_valid` is ignored. `hlt` takes priority over a same-cycle redirect.
- Outputs when `if_valid`=0: `if_inst`=0 (NOP/bubble), `if_pc`=0, `if_pc_inc`=0.

## Timing
- Reset values: `imem_req_valid`=0, `imem_req_addr`=RESET_PC, `if_valid`=0, `if_inst`/`if_pc`/`if_pc_inc`=0, state=BOOT, all counters 0.
- First request is valid in the first RUN cycle, i.e. the 2nd rising edge after `rst_n` deasserts.
- Fetch-to-decode latency: a response captured at edge E gives `if_valid`=1 after E. There is no bypass, so the minimum latency is request accepted + 2 cycles with a 1-cycle memory.
- Throughput: 1 instruction/cycle sustained when the memory latency ≤ DEPTH−1 cycles.
- Full: count=DEPTH blocks issue (live=0). Empty: `if_valid`=0.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Responses returning after reset are ignored because live=stale=0, and the memory must be reset together with this block.
- Response with live=stale=0 is an error condition; it is flagged by an assertion and dropped.

## Structure
- Shared package `cpu_pkg` holds: INST_W, PC_W, RESET_PC, NOP_INST (32'd0), and the fetch-state enum {FS_BOOT, FS_RUN, FS_HALTED}.
- Sub-module `inst_queue`: synchronous FIFO of {pc, inst}, DEPTH entries, with push/pop/flush, wrap-around pointers of log2(DEPTH) bits plus a separate count, and combinational head read.
- The top level holds the FSM, fetch_pc, response-PC, live/stale counters and the issue logic.

## Test plan
- Reset, 1-cycle memory always ready, `id_ready`=1 → requests at addresses 0,1,2,…; `if_pc` sequence 0,1,2,… one per cycle; the first `if_valid` is 2 cycles after the first request; `if_pc_inc` = `if_pc` + 1.
- `id_ready`=0 for 10 cycles → count saturates at 4, `imem_req_valid` drops, and no entry is lost or duplicated when `id_ready` returns.
- 3-cycle memory latency with 2 requests in flight; redirect to 0x40 → both old responses are dropped, and the next `if_pc` values are 0x40, 0x41.
- Redirect in the same cycle as a response and a pop → the response is dropped, the queue is empty next cycle, and the first new request is 0x40 one cycle later.
- `hlt` pulse with 2 queued entries and 1 in flight → `if_valid`=0 and `imem_req_valid`=0 from the next cycle onward, and a later redirect has no effect.
- `rst_n` pulsed low mid-stream → all outputs go to their reset values immediately, and fetching restarts at RESET_PC.
